// File: rtl/procsel_pkg.sv
// Shared constants for the ready-process selector: command bit positions,
// status word field positions and the process id type.
package procsel_pkg;

   // Command word ctrl bit indices (data_in[7:0])
   localparam int CTRL_CLR_ALL  = 0;
   localparam int CTRL_SET_MASK = 1;
   localparam int CTRL_CLR_ONE  = 2;
   localparam int CTRL_SET_ONE  = 3;

   // Command word field positions
   localparam int PID_LSB  = 8;
   localparam int DATA_LSB = 16;

   // Status word field positions
   localparam int VALID_BIT = 31;
   localparam int OVR_LSB   = 16;
   localparam int OVR_W     = 8;
   localparam int PID_W     = 5;

   typedef logic [PID_W-1:0] pid_t;
   typedef logic [OVR_W-1:0] ovr_t;

endpackage

// File: rtl/procsel_if.sv
// CPU-side IO port of the ready-process selector: one write word, one read
// word and the summary ready flag.
interface procsel_if;

   logic        wr;
   logic        rd;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        any_rdy;

   modport master (
      output wr, rd, data_in,
      input  data_out, any_rdy
   );

   modport slave (
      input  wr, rd, data_in,
      output data_out, any_rdy
   );

endinterface

// File: rtl/proc_rr_pick.sv
// Round-robin picker: finds the first set request starting at last+1 and
// wrapping modulo NUM_PROC. The request vector is doubled and rotated so a
// plain lowest-bit priority encode gives the offset from last+1.
module proc_rr_pick
   import procsel_pkg::*;
#(
   parameter int NUM_PROC = 16
) (
   input  logic [NUM_PROC-1:0] req,
   input  pid_t                last,
   output logic                found,
   output pid_t                pid
);

   logic [PID_W:0]      start;
   logic [PID_W:0]      sum;
   logic [NUM_PROC-1:0] rot;
   pid_t                off;

   // Rotate, priority encode the lowest set bit, then map back to a pid
   always_comb begin
      start = {1'b0, last} + (PID_W+1)'(1);
      rot   = NUM_PROC'({req, req} >> start);
      found = 1'b0;
      off   = '0;
      for (int i = NUM_PROC-1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = PID_W'(i);
         end
      end
      sum = start + {1'b0, off};
      if (sum >= (PID_W+1)'(NUM_PROC)) begin
         sum = sum - (PID_W+1)'(NUM_PROC);
      end
      pid = found ? sum[PID_W-1:0] : '0;
   end

endmodule

// File: rtl/procsel.sv
// Ready-process selector. Rising edges of proc_rdy are latched into a pending
// set; the next unmasked pending process is chosen round-robin and presented
// as the IO read word. A read of a valid selection pops that process.
module procsel
   import procsel_pkg::*;
#(
   parameter int NUM_PROC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_PROC-1:0] proc_rdy,
   procsel_if.slave            bus
);

   logic [NUM_PROC-1:0] prev_rdy;
   logic [NUM_PROC-1:0] hold_rdy;
   logic [NUM_PROC-1:0] pending;
   logic [NUM_PROC-1:0] mask;
   ovr_t                ovr_cnt;
   logic                sel_valid;
   pid_t                sel_pid;
   pid_t                last;

   logic [7:0]          ctrl;
   pid_t                cmd_pid;
   logic [15:0]         cmd_data;
   logic                pid_ok;
   logic                pop;
   logic                hit;
   logic [NUM_PROC-1:0] ev;
   logic [NUM_PROC-1:0] cmd_bit;
   logic [NUM_PROC-1:0] pop_bit;
   logic [NUM_PROC-1:0] set_vec;
   logic [NUM_PROC-1:0] clr_vec;
   logic [NUM_PROC-1:0] pend_nxt;
   logic [NUM_PROC-1:0] req;
   logic                pick_found;
   pid_t                pick_pid;
   logic                unused_bits;

   // Command decode, edge detection and next pending set (set beats clear)
   always_comb begin
      ctrl     = bus.wr ? bus.data_in[7:0] : 8'h00;
      cmd_pid  = bus.data_in[PID_LSB +: PID_W];
      cmd_data = bus.data_in[DATA_LSB +: 16];
      pid_ok   = int'(cmd_pid) < NUM_PROC;
      cmd_bit  = pid_ok ? (NUM_PROC'(1) << cmd_pid) : '0;
      pop      = bus.rd & sel_valid;
      pop_bit  = pop ? (NUM_PROC'(1) << sel_pid) : '0;
      // hold_rdy masks levels that were already high during reset
      ev       = proc_rdy & ~prev_rdy & ~hold_rdy;
      hit      = |(ev & pending);
      set_vec  = ev | (ctrl[CTRL_SET_ONE] ? cmd_bit : '0);
      clr_vec  = {NUM_PROC{ctrl[CTRL_CLR_ALL]}}
               | (ctrl[CTRL_CLR_ONE] ? cmd_bit : '0)
               | pop_bit;
      pend_nxt = (pending & ~clr_vec) | set_vec;
      req      = pending & mask;
   end

   // Command bits ctrl[7:4], pid[7:5] field spare bits and any mask data
   // above NUM_PROC are not decoded
   assign unused_bits = ^{ctrl[7:4], bus.data_in[15:13], cmd_data};

   proc_rr_pick #(
      .NUM_PROC (NUM_PROC)
   ) u_pick (
      .req   (req),
      .last  (last),
      .found (pick_found),
      .pid   (pick_pid)
   );

   // Ready edge history, pending set and mask
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_rdy <= '0;
         hold_rdy <= proc_rdy;
         pending  <= '0;
         mask     <= '1;
      end else begin
         prev_rdy <= proc_rdy;
         hold_rdy <= hold_rdy & proc_rdy;
         pending  <= pend_nxt;
         if (ctrl[CTRL_SET_MASK]) begin
            mask <= cmd_data[NUM_PROC-1:0];
         end
      end
   end

   // Saturating overrun counter; clear-all takes priority over an increment
   always_ff @(posedge clk) begin
      if (rst) begin
         ovr_cnt <= '0;
      end else if (ctrl[CTRL_CLR_ALL]) begin
         ovr_cnt <= '0;
      end else if (hit && (ovr_cnt != '1)) begin
         ovr_cnt <= ovr_cnt + ovr_t'(1);
      end
   end

   // Selection register: a pop inserts one invalid cycle and moves last
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_valid <= 1'b0;
         sel_pid   <= '0;
         last      <= PID_W'(NUM_PROC-1);
      end else if (pop) begin
         sel_valid <= 1'b0;
         sel_pid   <= '0;
         last      <= sel_pid;
      end else begin
         sel_valid <= pick_found;
         sel_pid   <= pick_pid;
      end
   end

   // Status word and summary flag, straight from registers
   always_comb begin
      bus.data_out                   = '0;
      bus.data_out[VALID_BIT]        = sel_valid;
      bus.data_out[OVR_LSB +: OVR_W] = ovr_cnt;
      bus.data_out[PID_W-1:0]        = sel_pid;
   end

   assign bus.any_rdy = |req;

endmodule

// File: tb/tb_procsel.sv
// Bench for procsel: directed scenarios followed by a randomized run, all
// compared each cycle against a process-list reference model.
module tb_procsel;

   localparam int NP = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NP-1:0] proc_rdy = '0;

   procsel_if bus ();

   procsel #(.NUM_PROC(NP)) dut (
      .clk      (clk),
      .rst      (rst),
      .proc_rdy (proc_rdy),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_pend [NP];
   bit m_mask [NP];
   bit m_lvl  [NP];   // last level counted as seen; a rise from 0 is an event
   int m_last;
   int m_ovr;
   bit m_sv;
   int m_sp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_dout();
      logic [31:0] d;
      d = 32'h0;
      d[31]    = m_sv;
      d[23:16] = m_ovr[7:0];
      d[4:0]   = m_sp[4:0];
      return d;
   endfunction

   function automatic logic m_any();
      for (int j = 0; j < NP; j++) if (m_pend[j] && m_mask[j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      logic [7:0] ctrl;
      int         pid;
      bit         pop, hit, found, ev, setb, clrb;
      int         pick;
      bit         np [NP];
      if (rst) begin
         for (int j = 0; j < NP; j++) begin
            m_pend[j] = 0;
            m_mask[j] = 1;
            m_lvl[j]  = proc_rdy[j];
         end
         m_last = NP-1; m_ovr = 0; m_sv = 0; m_sp = 0;
         return;
      end
      ctrl = bus.wr ? bus.data_in[7:0] : 8'h00;
      pid  = int'(bus.data_in[12:8]);
      pop  = bus.rd && m_sv;
      hit  = 0;
      for (int j = 0; j < NP; j++) begin
         ev   = proc_rdy[j] && !m_lvl[j];
         if (ev && m_pend[j]) hit = 1;
         setb = ev || (ctrl[3] && pid == j);
         clrb = ctrl[0] || (ctrl[2] && pid == j) || (pop && m_sp == j);
         np[j] = setb ? 1'b1 : (clrb ? 1'b0 : m_pend[j]);
      end
      // selection from the registers as they were before this edge
      found = 0; pick = 0;
      for (int k = 1; k <= NP; k++) begin
         if (!found && m_pend[(m_last + k) % NP] && m_mask[(m_last + k) % NP]) begin
            found = 1;
            pick  = (m_last + k) % NP;
         end
      end
      if (pop) begin
         m_last = m_sp; m_sv = 0; m_sp = 0;
      end else begin
         m_sv = found; m_sp = pick;
      end
      if (ctrl[0])    m_ovr = 0;
      else if (hit)   m_ovr = (m_ovr >= 255) ? 255 : m_ovr + 1;
      for (int j = 0; j < NP; j++) begin
         if (ctrl[1]) m_mask[j] = bus.data_in[16 + j];
         m_pend[j] = np[j];
         m_lvl[j]  = proc_rdy[j];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("model_dout", bus.data_out, m_dout());
      check("model_any", {31'b0, bus.any_rdy}, {31'b0, m_any()});
   endtask

   task automatic wr_cmd(input logic [31:0] d);
      bus.wr = 1'b1; bus.data_in = d;
      tick();
      bus.wr = 1'b0; bus.data_in = 32'h0;
   endtask

   task automatic pop_check(input string tag, input logic [31:0] exp);
      check(tag, bus.data_out, exp);
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      check({tag, "_bubble"}, {31'b0, bus.data_out[31]}, 32'h0);
      tick();
   endtask

   initial begin
      logic [31:0] r1, r2;
      logic [7:0]  rc;
      bus.wr = 1'b0; bus.rd = 1'b0; bus.data_in = 32'h0;

      // reset
      tick(); tick();
      check("reset_dout", bus.data_out, 32'h0);
      check("reset_any", {31'b0, bus.any_rdy}, 32'h0);
      rst = 1'b0;

      // basic event and pop
      proc_rdy[3] = 1'b1; tick();
      proc_rdy = '0; tick();
      pop_check("basic_sel3", 32'h8000_0003);
      check("basic_after_pop", bus.data_out, 32'h0);
      tick();
      check("basic_stays0", bus.data_out, 32'h0);

      // round robin after a pop of 5
      wr_cmd(32'h0000_0508); tick();
      pop_check("rr_pre5", 32'h8000_0005);
      proc_rdy = 16'h0222; tick();
      proc_rdy = '0; tick();
      pop_check("rr_first9", 32'h8000_0009);
      pop_check("rr_then1", 32'h8000_0001);
      pop_check("rr_then5", 32'h8000_0005);
      check("rr_empty", bus.data_out, 32'h0);

      // mask
      wr_cmd(32'hFFFD_0002);
      proc_rdy[1] = 1'b1; tick();
      proc_rdy = '0; tick(); tick();
      check("mask_hidden", bus.data_out, 32'h0);
      check("mask_any0", {31'b0, bus.any_rdy}, 32'h0);
      wr_cmd(32'hFFFF_0002);
      check("mask_any1", {31'b0, bus.any_rdy}, 32'h1);
      tick();
      pop_check("mask_sel1", 32'h8000_0001);

      // set beats clear: event on 4 during its pop (also an overrun hit)
      proc_rdy[4] = 1'b1; tick();
      proc_rdy = '0; tick();
      check("sbc_sel4", bus.data_out, 32'h8000_0004);
      bus.rd = 1'b1; proc_rdy[4] = 1'b1; tick();
      bus.rd = 1'b0; proc_rdy = '0;
      check("sbc_bubble", bus.data_out, 32'h0001_0000);
      tick();
      pop_check("sbc_resel4", 32'h8001_0004);

      // overrun saturation and clear-all
      for (int i = 0; i < 300; i++) begin
         proc_rdy[2] = 1'b1; tick();
         proc_rdy[2] = 1'b0; tick();
      end
      check("ovr_sat", bus.data_out, 32'h80FF_0002);
      wr_cmd(32'h0000_0001);
      check("clr_ovr", bus.data_out, 32'h8000_0002);
      check("clr_any", {31'b0, bus.any_rdy}, 32'h0);
      tick();
      check("clr_empty", bus.data_out, 32'h0);

      // force set, then an out-of-range pid
      wr_cmd(32'h0000_0708); tick();
      pop_check("force7", 32'h8000_0007);
      wr_cmd(32'h0000_1408); tick();
      check("force20_dout", bus.data_out, 32'h0);
      check("force20_any", {31'b0, bus.any_rdy}, 32'h0);

      // reset mid-operation with proc_rdy[6] held high across it
      proc_rdy[6] = 1'b1; tick();
      rst = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.data_in = 32'h0000_0208;
      tick();
      rst = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.data_in = 32'h0;
      check("rst_mid_dout", bus.data_out, 32'h0);
      tick(); tick();
      check("held_no_event", bus.data_out, 32'h0);
      check("held_any0", {31'b0, bus.any_rdy}, 32'h0);
      proc_rdy = '0; tick();
      proc_rdy[6] = 1'b1; tick(); tick();
      pop_check("held_rearm6", 32'h8000_0006);
      proc_rdy = '0;

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int j = 0; j < NP; j++) begin
            if ($urandom_range(0, 7) == 0) proc_rdy[j] = ~proc_rdy[j];
         end
         bus.rd = ($urandom_range(0, 2) == 0);
         bus.wr = ($urandom_range(0, 9) == 0);
         r1 = $urandom(); r2 = $urandom();
         rc = r1[7:0];
         if ($urandom_range(0, 7) != 0) rc[0] = 1'b0;
         bus.data_in = {r1[31:16] | r2[31:16], 8'h00, rc};
         bus.data_in[12:8] = 5'($urandom_range(0, 19));
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
